// File: rtl/ahb_sram_slave.sv
`default_nettype none
// ahb_sram_slave: AHB-Lite SRAM target with programmable wait states and two-cycle ERROR response.
// Revision 1.0
module ahb_sram_slave #(
  parameter int MEM_BYTES   = 4096,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP
);

  localparam int WORDS = MEM_BYTES / 4;
  localparam int IDX_W = $clog2(WORDS);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t             state, state_n;
  logic [3:0]         cnt, cnt_n;
  logic [IDX_W+1:0]   addr_q;
  logic               write_q;
  logic [1:0]         size_q;
  logic               valid, bad;
  logic [3:0]         lanes;
  logic [31:0]        mem [WORDS];

  logic unused_ok;
  assign unused_ok = ^{HBURST, HPROT, HTRANS[0]};

  // Only states that drive HREADYOUT high can accept a new address phase.
  assign valid = (state == S_IDLE || state == S_DATA || state == S_ERR2)
                 && HREADY && HSEL && HTRANS[1];
  assign bad   = (HSIZE > 3'b010)
                 || (HSIZE == 3'b001 && HADDR[0])
                 || (HSIZE == 3'b010 && HADDR[1:0] != 2'b00)
                 || (HADDR >= 32'(MEM_BYTES));

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      S_WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt == 4'd1) state_n = S_DATA;
      end
      S_ERR1: state_n = S_ERR2;
      default: begin
        state_n = S_IDLE;
        if (valid) begin
          if (bad) begin
            state_n = S_ERR1;
          end else if (WAIT_STATES == 0) begin
            state_n = S_DATA;
          end else begin
            state_n = S_WAIT;
            cnt_n   = 4'(WAIT_STATES);
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 2'b00;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (valid) begin
        addr_q  <= HADDR[IDX_W+1:0];
        write_q <= HWRITE;
        size_q  <= HSIZE[1:0];
      end
    end
  end

  // Little-endian byte lanes; only sizes 0..2 ever reach the data phase.
  always_comb begin
    lanes = 4'b0000;
    case (size_q)
      2'b00:   lanes = 4'b0001 << addr_q[1:0];
      2'b01:   lanes = addr_q[1] ? 4'b1100 : 4'b0011;
      default: lanes = 4'b1111;
    endcase
  end

  // Memory is never cleared; a write pending when reset hits is dropped.
  always_ff @(posedge HCLK) begin
    if (!HRESET && state == S_DATA && write_q) begin
      for (int b = 0; b < 4; b++) begin
        if (lanes[b]) mem[addr_q[IDX_W+1:2]][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  assign HREADYOUT = !(state == S_WAIT || state == S_ERR1);
  assign HRESP     = (state == S_ERR1 || state == S_ERR2) ? 2'b01 : 2'b00;
  assign HRDATA    = (state == S_DATA && !write_q) ? mem[addr_q[IDX_W+1:2]] : 32'h0;

endmodule
`default_nettype wire
